// File: rtl/dac_spi_tx.sv
// SPI mode-0 transmitter for a 12-bit MCP4921-class DAC.
// It sends one 16-bit frame, MSB first, and then pulses LDAC to update the output.
module dac_spi_tx #(
    parameter int unsigned CLK_DIV = 2,
    parameter logic        CH_SEL  = 1'b0,
    parameter logic        BUF     = 1'b0,
    parameter logic        GAIN_1X = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] din,
    input  logic        din_shdn,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        cs_dac,
    output logic        sclk_dac,
    output logic        mosi_dac,
    output logic        ldac_dac,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        LDAC
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] frame_q, frame_d;
    logic        cs_q, cs_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        ldac_q, ldac_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;
    logic        phase_end;

    assign phase_end = (cnt_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        cs_d      = cs_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ldac_d    = ldac_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ready_d   = ready_q;

        case (state_q)
            IDLE: begin
                if (din_valid && ready_q) begin
                    frame_d   = {CH_SEL, BUF, GAIN_1X, ~din_shdn, din};
                    mosi_d    = CH_SEL;
                    cs_d      = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = 8'd0;
                    bit_cnt_d = 5'd0;
                    state_d   = SETUP;
                end
            end

            SETUP: begin
                if (phase_end) begin
                    cnt_d   = 8'd0;
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            SHIFT: begin
                if (!phase_end) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = 8'd0;
                    if (sclk_q) begin
                        // The falling edge presents the next bit. After bit 15, mosi is held for the trailing low phase.
                        sclk_d    = 1'b0;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q != 5'd15) begin
                            frame_d = {frame_q[14:0], 1'b0};
                            mosi_d  = frame_q[14];
                        end
                    end else if (bit_cnt_q == 5'd16) begin
                        cs_d    = 1'b1;
                        mosi_d  = 1'b0;
                        ldac_d  = 1'b0;
                        state_d = LDAC;
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end

            LDAC: begin
                if (phase_end) begin
                    cnt_d     = 8'd0;
                    bit_cnt_d = 5'd0;
                    ldac_d    = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    ready_d   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            bit_cnt_q <= 5'd0;
            frame_q   <= 16'd0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ldac_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ldac_q    <= ldac_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign din_ready = ready_q;
    assign cs_dac    = cs_q;
    assign sclk_dac  = sclk_q;
    assign mosi_dac  = mosi_q;
    assign ldac_dac  = ldac_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboard bench for dac_spi_tx. It runs two instances, one with CLK_DIV=2 and one with CLK_DIV=1.
// A monitor captures each SPI frame and checks it against hand-computed expected words.
module tb_dac_spi_tx;

    logic        clk;
    logic        rst;
    logic [11:0] din       [2];
    logic        din_shdn  [2];
    logic        din_valid [2];
    logic [1:0]  din_ready;
    logic [1:0]  cs_dac;
    logic [1:0]  sclk_dac;
    logic [1:0]  mosi_dac;
    logic [1:0]  ldac_dac;
    logic [1:0]  busy;
    logic [1:0]  done;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc_cnt  = 0;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    logic [15:0] cap       [2];
    int          rises     [2];
    int          cs_len    [2];
    int          ldac_len  [2];
    int          fcyc      [2];
    logic        in_frame  [2];
    logic        prev_sclk [2];
    logic        prev_mosi [2];
    logic        edge_viol [2];
    logic        idle_viol [2];

    dac_spi_tx #(.CLK_DIV(2)) u_dut_div2 (
        .clk(clk), .rst(rst),
        .din(din[0]), .din_shdn(din_shdn[0]), .din_valid(din_valid[0]),
        .din_ready(din_ready[0]), .cs_dac(cs_dac[0]), .sclk_dac(sclk_dac[0]),
        .mosi_dac(mosi_dac[0]), .ldac_dac(ldac_dac[0]), .busy(busy[0]), .done(done[0])
    );

    dac_spi_tx #(.CLK_DIV(1)) u_dut_div1 (
        .clk(clk), .rst(rst),
        .din(din[1]), .din_shdn(din_shdn[1]), .din_valid(din_valid[1]),
        .din_ready(din_ready[1]), .cs_dac(cs_dac[1]), .sclk_dac(sclk_dac[1]),
        .mosi_dac(mosi_dac[1]), .ldac_dac(ldac_dac[1]), .busy(busy[1]), .done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitorStep(input int i);
        int d;
        string tag;
        logic [15:0] want;
        d   = (i == 0) ? 2 : 1;
        tag = (i == 0) ? "div2" : "div1";
        if (cs_dac[i] && sclk_dac[i]) idle_viol[i] = 1'b1;
        if (!in_frame[i] && !cs_dac[i]) begin
            in_frame[i]  = 1'b1;
            fcyc[i]      = 0;
            cap[i]       = 16'd0;
            rises[i]     = 0;
            cs_len[i]    = 0;
            ldac_len[i]  = 0;
            edge_viol[i] = 1'b0;
        end
        if (in_frame[i]) begin
            fcyc[i]++;
            if (!cs_dac[i]) cs_len[i]++;
            if (!ldac_dac[i]) ldac_len[i]++;
            if (sclk_dac[i] && !prev_sclk[i]) begin
                rises[i]++;
                cap[i] = {cap[i][14:0], mosi_dac[i]};
            end
            if (sclk_dac[i] && (mosi_dac[i] != prev_mosi[i])) edge_viol[i] = 1'b1;
        end
        if (done[i]) begin
            if (((i == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
                checkOutput({tag, " unexpected_done"}, 32'd1, 32'd0);
            end else begin
                want = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                checkOutput({tag, " frame"}, 32'(cap[i]), 32'(want));
                checkOutput({tag, " sclk_rises"}, 32'(rises[i]), 32'd16);
                checkOutput({tag, " cs_low_cycles"}, 32'(cs_len[i]), 32'(33 * d));
                checkOutput({tag, " ldac_low_cycles"}, 32'(ldac_len[i]), 32'(d));
                checkOutput({tag, " done_cycle"}, 32'(fcyc[i]), 32'(34 * d + 1));
                checkOutput({tag, " mosi_change_while_sclk_high"}, 32'(edge_viol[i]), 32'd0);
                checkOutput({tag, " sclk_high_while_cs_high"}, 32'(idle_viol[i]), 32'd0);
                checkOutput({tag, " ready_at_done"}, 32'(din_ready[i]), 32'd1);
                checkOutput({tag, " busy_at_done"}, 32'(busy[i]), 32'd0);
            end
            in_frame[i]  = 1'b0;
            idle_viol[i] = 1'b0;
        end else if (in_frame[i] && !busy[i]) begin
            in_frame[i] = 1'b0;
        end
        prev_sclk[i] = sclk_dac[i];
        prev_mosi[i] = mosi_dac[i];
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) monitorStep(i);
    end

    // Waits for ready, offers one sample for a single cycle, and optionally queues the expected frame.
    task automatic applyStimulus(input int i, input logic [11:0] d, input logic s,
                                 input logic [15:0] exp, input bit push);
        int t;
        t = 0;
        while (!din_ready[i] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!din_ready[i]) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
            return;
        end
        din[i]       = d;
        din_shdn[i]  = s;
        din_valid[i] = 1'b1;
        if (push) begin
            if (i == 0) exp_q0.push_back(exp);
            else        exp_q1.push_back(exp);
        end
        @(negedge clk);
        din_valid[i] = 1'b0;
    endtask

    task automatic checkIdleOutputs(input int i, input string tag);
        checkOutput({tag, " cs_dac"},    32'(cs_dac[i]),    32'd1);
        checkOutput({tag, " sclk_dac"},  32'(sclk_dac[i]),  32'd0);
        checkOutput({tag, " mosi_dac"},  32'(mosi_dac[i]),  32'd0);
        checkOutput({tag, " ldac_dac"},  32'(ldac_dac[i]),  32'd1);
        checkOutput({tag, " busy"},      32'(busy[i]),      32'd0);
        checkOutput({tag, " done"},      32'(done[i]),      32'd0);
        checkOutput({tag, " din_ready"}, 32'(din_ready[i]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t_hs [4];
        int t;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            din[i]       = 12'd0;
            din_shdn[i]  = 1'b0;
            din_valid[i] = 1'b0;
            in_frame[i]  = 1'b0;
            prev_sclk[i] = 1'b0;
            prev_mosi[i] = 1'b0;
            edge_viol[i] = 1'b0;
            idle_viol[i] = 1'b0;
            cap[i]       = 16'd0;
            rises[i]     = 0;
            cs_len[i]    = 0;
            ldac_len[i]  = 0;
            fcyc[i]      = 0;
        end
        repeat (3) @(negedge clk);
        checkIdleOutputs(0, "reset div2");
        checkIdleOutputs(1, "reset div1");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic frames");
        applyStimulus(0, 12'hABC, 1'b0, 16'h3ABC, 1'b1);
        applyStimulus(1, 12'h555, 1'b0, 16'h3555, 1'b1);
        applyStimulus(0, 12'h000, 1'b1, 16'h2000, 1'b1);
        applyStimulus(0, 12'hFFF, 1'b0, 16'h3FFF, 1'b1);

        $display("[TB] back-to-back with din_valid held high");
        t = 0;
        while (!din_ready[0] && t < 200) begin
            @(negedge clk);
            t++;
        end
        din_shdn[0]  = 1'b0;
        din[0]       = 12'h001;
        din_valid[0] = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            t = 0;
            while (!din_ready[0] && t < 200) begin
                @(negedge clk);
                t++;
            end
            t_hs[n] = cyc_cnt;
            exp_q0.push_back(16'h3000 | 16'(n));
            @(negedge clk);
            din[0] = 12'(n + 1);
        end
        din_valid[0] = 1'b0;
        checkOutput("b2b period 1-2", 32'(t_hs[2] - t_hs[1]), 32'd69);
        checkOutput("b2b period 2-3", 32'(t_hs[3] - t_hs[2]), 32'd69);

        $display("[TB] reset in the middle of a frame");
        applyStimulus(0, 12'h777, 1'b0, 16'h0000, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkIdleOutputs(0, "midframe reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(0, 12'h123, 1'b0, 16'h3123, 1'b1);

        t = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        checkOutput("pending div2 frames", 32'(exp_q0.size()), 32'd0);
        checkOutput("pending div1 frames", 32'(exp_q1.size()), 32'd0);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
